// File: rtl/i_fetch_mux_if.sv
// rtl/i_fetch_mux_if.sv - fetch request/response channel between core fetch stage and fetch mux
interface i_fetch_mux_if #(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 14
);
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_LEN-1:0] req_addr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [XLEN-1:0]     rsp_data;
    logic                rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/i_fetch_mux.sv
// rtl/i_fetch_mux.sv - instruction fetch mux over N synchronous-read instruction banks
module i_fetch_mux #(
    parameter int                            XLEN      = 32,
    parameter int                            ADDR_LEN  = 14,
    parameter int                            NUM_BANKS = 2,
    parameter logic [NUM_BANKS*ADDR_LEN-1:0] BANK_BASE = {14'h2000, 14'h0000},
    parameter logic [ADDR_LEN-1:0]           TOP_ADDR  = 14'h3FFF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    i_fetch_mux_if.slave                     fetch,
    output logic [NUM_BANKS-1:0]             bank_en,
    output logic [NUM_BANKS*(ADDR_LEN-2)-1:0] bank_addr,
    input  logic [NUM_BANKS*XLEN-1:0]        bank_data
);
    localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WA    = ADDR_LEN - 2;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LIVE  = 2'd1;
    localparam logic [1:0] S_HELD  = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    logic [1:0]       state;
    logic [SEL_W-1:0] sel_q;
    logic [XLEN-1:0]  hold_q;

    logic [SEL_W-1:0] sel;
    logic [WA-1:0]    offset;
    logic             fault;
    logic             req_ready;
    logic             accept;
    logic [XLEN-1:0]  live_word;

    // Bases are ascending, so the last matching bank is the highest one at or below the address.
    always_comb begin
        sel    = '0;
        offset = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (fetch.req_addr >= BANK_BASE[i*ADDR_LEN +: ADDR_LEN]) begin
                sel    = SEL_W'(i);
                offset = fetch.req_addr[ADDR_LEN-1:2] - BANK_BASE[i*ADDR_LEN+2 +: WA];
            end
        end
    end

    assign fault     = (fetch.req_addr[1:0] != 2'b00) || (fetch.req_addr > TOP_ADDR);
    assign req_ready = !rst && !flush && (state == S_EMPTY || fetch.rsp_ready);
    assign accept    = fetch.req_valid && req_ready;

    always_comb begin
        bank_en   = '0;
        bank_addr = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (sel == SEL_W'(i)) begin
                bank_en[i]            = accept && !fault;
                bank_addr[i*WA +: WA] = offset;
            end
        end
    end

    always_comb begin
        live_word = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                live_word = bank_data[i*XLEN +: XLEN];
            end
        end
    end

    assign fetch.req_ready = req_ready;
    assign fetch.rsp_valid = (state != S_EMPTY);
    assign fetch.rsp_err   = (state == S_ERR);
    assign fetch.rsp_data  = (state == S_LIVE) ? live_word :
                             (state == S_HELD) ? hold_q    : '0;

    // Bank output is only valid the cycle after the read, so a stalled response is captured once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_EMPTY;
            sel_q  <= '0;
            hold_q <= '0;
        end else if (flush) begin
            state <= S_EMPTY;
        end else if (accept) begin
            sel_q <= sel;
            state <= fault ? S_ERR : S_LIVE;
        end else if (state == S_LIVE && !fetch.rsp_ready) begin
            hold_q <= live_word;
            state  <= S_HELD;
        end else if (state != S_EMPTY && fetch.rsp_ready) begin
            state <= S_EMPTY;
        end
    end
endmodule

// File: tb/tb_i_fetch_mux.sv
// tb/tb_i_fetch_mux.sv - table-driven self-checking bench for i_fetch_mux
module tb_i_fetch_mux;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  bank_en;
    logic [23:0] bank_addr;
    logic [63:0] bank_data;
    logic [31:0] bank_q [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    i_fetch_mux_if #(.XLEN(32), .ADDR_LEN(14)) fetch ();

    i_fetch_mux #(
        .XLEN(32), .ADDR_LEN(14), .NUM_BANKS(2),
        .BANK_BASE({14'h2000, 14'h0000}), .TOP_ADDR(14'h2FFF)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .fetch(fetch),
        .bank_en(bank_en), .bank_addr(bank_addr), .bank_data(bank_data)
    );

    // Bank model: word = tag | word index; output scrambles whenever the bank is not read.
    always @(posedge clk) begin
        if (bank_en[0]) bank_q[0] <= 32'hA000_0000 | {20'h0, bank_addr[11:0]};
        else            bank_q[0] <= bank_q[0] ^ 32'h5555_5555;
        if (bank_en[1]) bank_q[1] <= 32'hB000_0000 | {20'h0, bank_addr[23:12]};
        else            bank_q[1] <= bank_q[1] ^ 32'h5555_5555;
    end
    assign bank_data = {bank_q[1], bank_q[0]};

    typedef struct {
        logic        rst;
        logic        flush;
        logic        rv;
        logic [13:0] addr;
        logic        rr;
        logic        e_rdy;
        logic [1:0]  e_en;
        logic [23:0] e_ba;
        logic        e_rv;
        logic        e_err;
        logic [31:0] e_d;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic rv, input logic [13:0] a, input logic rr);
        rst             = r;
        flush           = f;
        fetch.req_valid = rv;
        fetch.req_addr  = a;
        fetch.rsp_ready = rr;
    endtask

    initial begin
        int waited;
        //                rst   flush rv    addr      rr    rdy   en     bank_addr    rv    err   data
        vecs.push_back('{1'b1, 1'b0, 1'b1, 14'h0000, 1'b1, 1'b0, 2'b00, 24'h000000, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0000, 1'b1, 1'b1, 2'b01, 24'h000000, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h2008, 1'b1, 1'b1, 2'b10, 24'h002000, 1'b1, 1'b0, 32'hA000_0000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h1FFC, 1'b1, 1'b1, 2'b01, 24'h0007FF, 1'b1, 1'b0, 32'hB000_0002});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h2000, 1'b1, 1'b1, 2'b10, 24'h000000, 1'b1, 1'b0, 32'hA000_07FF});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0010, 1'b1, 1'b1, 2'b01, 24'h000004, 1'b1, 1'b0, 32'hB000_0000});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0014, 1'b0, 1'b0, 2'b00, 24'h000005, 1'b1, 1'b0, 32'hA000_0004});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0014, 1'b0, 1'b0, 2'b00, 24'h000005, 1'b1, 1'b0, 32'hA000_0004});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0014, 1'b0, 1'b0, 2'b00, 24'h000005, 1'b1, 1'b0, 32'hA000_0004});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0014, 1'b1, 1'b1, 2'b01, 24'h000005, 1'b1, 1'b0, 32'hA000_0004});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0006, 1'b1, 1'b1, 2'b00, 24'h000001, 1'b1, 1'b0, 32'hA000_0005});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h3000, 1'b1, 1'b1, 2'b00, 24'h400000, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0020, 1'b1, 1'b1, 2'b00, 24'h000008, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0020, 1'b1, 1'b1, 2'b01, 24'h000008, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 14'h0024, 1'b1, 1'b0, 2'b00, 24'h000009, 1'b1, 1'b0, 32'hA000_0008});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0024, 1'b1, 1'b1, 2'b00, 24'h000009, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0010, 1'b0, 1'b1, 2'b01, 24'h000004, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0010, 1'b0, 1'b0, 2'b00, 24'h000004, 1'b1, 1'b0, 32'hA000_0004});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 14'h0010, 1'b0, 1'b0, 2'b00, 24'h000004, 1'b1, 1'b0, 32'hA000_0004});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0000, 1'b1, 1'b1, 2'b01, 24'h000000, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b1, 2'b00, 24'h000000, 1'b1, 1'b0, 32'hA000_0000});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b1, 2'b00, 24'h000000, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0002, 1'b1, 1'b1, 2'b00, 24'h000000, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 14'h0000, 1'b0, 1'b0, 2'b00, 24'h000000, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b1, 2'b00, 24'h000000, 1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 14'h0000, 1'b1, 1'b1, 2'b00, 24'h000000, 1'b0, 1'b0, 32'h0});

        drive(1'b1, 1'b0, 1'b0, 14'h0, 1'b1);
        repeat (2) @(posedge clk);

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].flush, vecs[k].rv, vecs[k].addr, vecs[k].rr);
            #1;
            chk("req_ready", k, 32'(fetch.req_ready), 32'(vecs[k].e_rdy));
            chk("bank_en",   k, 32'(bank_en),         32'(vecs[k].e_en));
            chk("bank_addr", k, 32'(bank_addr),       32'(vecs[k].e_ba));
            chk("rsp_valid", k, 32'(fetch.rsp_valid), 32'(vecs[k].e_rv));
            chk("rsp_err",   k, 32'(fetch.rsp_err),   32'(vecs[k].e_err));
            chk("rsp_data",  k, fetch.rsp_data,       vecs[k].e_d);
        end

        // Long stall on a bank1 response: data must stay put while the bank output keeps changing.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 14'h2004, 1'b0);
        #1;
        chk("stall_accept_en", 100, 32'(bank_en), 32'h2);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 14'h0000, 1'b0);
        waited = 0;
        while (!fetch.rsp_valid && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        chk("stall_rsp_timeout", 101, 32'(fetch.rsp_valid), 32'h1);
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_data",  102 + c, fetch.rsp_data,        32'hB000_0001);
            chk("stall_ready", 102 + c, 32'(fetch.req_ready),  32'h0);
            chk("stall_en",    102 + c, 32'(bank_en),          32'h0);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b1, 14'h0000, 1'b1);
        #1;
        chk("release_en",   110, 32'(bank_en),        32'h1);
        chk("release_data", 110, fetch.rsp_data,      32'hB000_0001);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 14'h0000, 1'b1);
        #1;
        chk("release_next", 111, fetch.rsp_data,      32'hA000_0000);
        @(negedge clk);
        #1;
        chk("release_idle", 112, 32'(fetch.rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/i_fetch_mux.md
Name: i_fetch_mux

Overview:
Parametrised instruction-fetch mux between the core fetch stage and N synchronous-read instruction memories (ROM, RAM, further banks).
- Decodes the byte address to a bank and issues a word read to that bank.
- Returns data one cycle later over a valid/ready response channel, holding the data under backpressure.
- Flags misaligned or unmapped fetches and supports flush on redirect.

Parameters:
XLEN, 32, instruction word width (bits)
ADDR_LEN, 14, byte address width
NUM_BANKS, 2, number of instruction banks (>=1)
BANK_BASE, {14'h2000,14'h0000}, packed NUM_BANKS*ADDR_LEN: word-aligned byte base of each bank; bank i at slice i; strictly ascending; bank 0 base = 0
TOP_ADDR, 14'h3FFF, last valid byte address (inclusive)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  drop in-flight response (PC redirect)
req_valid  in  1  fetch request
req_ready  out  1  request accepted when req_valid&&req_ready
req_addr  in  ADDR_LEN  fetch byte address
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_data  out  XLEN  instruction word; 0 when rsp_err
rsp_err  out  1  fetch fault (misaligned/unmapped)
bank_en  out  NUM_BANKS  one-hot read enable
bank_addr  out  NUM_BANKS*(ADDR_LEN-2)  word address per bank, relative to its base
bank_data  in  NUM_BANKS*XLEN  bank read data, valid cycle after bank_en

Behaviour:
- Reset (rst=1 at posedge): state=EMPTY; rsp_valid=0, rsp_err=0, hold register=0, sel register=0. Combinational outputs during/after reset: bank_en=0, rsp_data=0.
- Bank decode (combinational): sel = highest i with req_addr >= BANK_BASE[i].
- Word offset: offset = (req_addr - BANK_BASE[sel])[ADDR_LEN-1:2], driven on the sel slice of bank_addr. Unselected slices = 0.
- Fault: req_addr[1:0] != 0 OR req_addr > TOP_ADDR.
- req_ready = !flush && (state==EMPTY || rsp_ready).
- accept = req_valid && req_ready.
- bank_en[sel] = accept && !fault. No bank enable on fault.
- Latency: the accepted request's response appears the next cycle, rsp_valid=1. Throughput one fetch/cycle while rsp_ready=1.
- State machine: EMPTY, LIVE, HELD, ERR.
  - EMPTY: accept & !fault -> LIVE; accept & fault -> ERR.
  - LIVE: rsp_data = bank_data[sel_q] (direct from bank).
    - rsp_ready=1: accept & !fault -> LIVE; accept & fault -> ERR; no accept -> EMPTY.
    - rsp_ready=0: hold reg <= bank_data[sel_q]; -> HELD.
  - HELD: rsp_data = hold reg. rsp_ready=1 -> same transitions as LIVE.
  - ERR: rsp_err=1, rsp_data=0. rsp_ready=1 -> same transitions as LIVE.
- sel_q, err_q registered on accept only.
- Stable outputs: while rsp_valid=1 and rsp_ready=0, rsp_data/rsp_err must not change. No bank is re-read.
- flush (highest priority after rst):
  - Next state = EMPTY, rsp_valid=0 next cycle.
  - req_ready=0 in the flush cycle, so no accept and no bank_en.
  - A response presented in the flush cycle must not be counted by the consumer; the consumer ignores it on flush.
- Simultaneous consume + accept: allowed. rsp_ready=1 in LIVE/HELD/ERR with a new accept goes straight to the next response, with no bubble.
- Reset mid-operation: any held or in-flight response is discarded. No bank_en in the reset cycle.
- NUM_BANKS=1: sel always 0. Only the alignment/TOP_ADDR faults apply.

Test Plan:
1. Reset, req_valid=1 addr 0x0000 -> bank_en=2'b01, bank_addr slice0=0. Next cycle rsp_valid=1, rsp_data=bank0 word 0, rsp_err=0.
2. addr 0x2008, rsp_ready=1 -> bank_en=2'b10, slice1=12'h002. Next cycle rsp_data=bank1 data. Back-to-back 0x1FFC then 0x2000 gives consecutive responses from bank0 then bank1, no bubble.
3. Accept 0x0010, rsp_ready=0 for 3 cycles while bank_data changes -> rsp_data stays the captured value; req_ready=0; bank_en=0. On rsp_ready=1, release and accept the next request the same cycle.
4. addr 0x0006 (misaligned) and addr 0x3FFC+4 wrap-free out-of-range value 0x3FFF+1 (14-bit: use TOP_ADDR=0x2FFF, addr 0x3000) -> bank_en=0; next cycle rsp_valid=1, rsp_err=1, rsp_data=0.
5. Accept 0x0020, then flush=1 the next cycle with req_valid=1 -> req_ready=0, bank_en=0; the following cycle rsp_valid=0, state EMPTY.
6. rst=1 while in HELD -> next cycle rsp_valid=0, rsp_data=0, bank_en=0. The first request after reset behaves as scenario 1.
